// File: rtl/perf_cnt_pkg.sv
// perf_cnt_pkg
// Shared constants and types for the APB performance-counter bank:
// register byte offsets, the counter window base/stride, and the 64-bit
// container type used for the hold register path and read muxing.
package perf_cnt_pkg;

  localparam logic [31:0] OFF_CLEAR    = 32'h000;
  localparam logic [31:0] OFF_START    = 32'h004;
  localparam logic [31:0] OFF_STOP     = 32'h008;
  localparam logic [31:0] OFF_OVF      = 32'h00C;
  localparam logic [31:0] OFF_IRQ_MASK = 32'h010;

  localparam logic [31:0] CNT_BASE   = 32'h100;
  localparam logic [31:0] CNT_STRIDE = 32'h008;

  typedef logic [63:0] cnt_t;

endpackage

// File: rtl/perf_cnt_slice.sv
// perf_cnt_slice
// One counter channel: the counter itself, its active bit and its sticky
// overflow bit. Clear beats increment; a new overflow beats W1C.
// Ports:
//   HCLK, HRESET      clock, synchronous active-high reset
//   clr               zero counter and overflow bit this cycle
//   start / stop      set / clear the active bit
//   ovf_clr           W1C request for the overflow bit
//   inc               increment applied when active
//   cnt, act, ovf     registered counter, active bit, overflow bit
module perf_cnt_slice
  import perf_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 48,
  parameter int INC_WIDTH = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 ovf_clr,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 act,
  output logic                 ovf
);

  // One extra bit captures the carry out of the top counter bit.
  logic [CNT_WIDTH:0] sum;
  assign sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt <= '0;
      act <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (start)     act <= 1'b1;
      else if (stop) act <= 1'b0;

      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (act) cnt <= sum[CNT_WIDTH-1:0];
        if (act && sum[CNT_WIDTH]) ovf <= 1'b1;
        else if (ovf_clr)          ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_perf_cnt_bank.sv
// apb_perf_cnt_bank
// APB bank of NUM_CNT event counters with start/stop/clear masks, sticky
// overflow status and a shared hold register so that a CNT_LO read followed
// by a CNT_HI read yields one coherent sample of a wide counter.
// Optional feature macro: PERF_CNT_OVF_IRQ_EN (OVF_IRQ_MASK register and a
// registered overflow interrupt); without it irq_o is tied low.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   PADDR, PWDATA, PWRITE,
//   PSEL, PENABLE                APB request
//   PRDATA, PREADY, PSLVERR      APB response (PREADY tied high)
//   evt_inc_i                    per-channel increments, INC_WIDTH each
//   cnt_act_o                    active mask
//   irq_o                        overflow interrupt
module apb_perf_cnt_bank
  import perf_cnt_pkg::*;
#(
  parameter int NUM_CNT        = 8,
  parameter int CNT_WIDTH      = 48,
  parameter int INC_WIDTH      = 1,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [APB_ADDR_WIDTH-1:0]    PADDR,
  input  logic [31:0]                  PWDATA,
  input  logic                         PWRITE,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [NUM_CNT*INC_WIDTH-1:0] evt_inc_i,
  output logic [NUM_CNT-1:0]           cnt_act_o,
  output logic                         irq_o
);

  logic                 access, err, wr_ok, lo_rd;
  logic                 in_cnt, idx_ok, hi_sel;
  logic [31:0]          off, rel, idx, rdata, hold_q;
  logic [NUM_CNT-1:0]   wdata_m, act_vec, ovf_vec;
  logic [NUM_CNT-1:0]   clr_vec, start_vec, stop_vec, ovf_w1c;
  logic [CNT_WIDTH-1:0] cnt_arr [NUM_CNT];
  cnt_t                 sel_cnt;
  logic                 unused_bits;

`ifdef PERF_CNT_OVF_IRQ_EN
  logic [NUM_CNT-1:0]   irq_mask_q;
  logic                 irq_q;
`endif

  assign access  = PSEL & PENABLE;
  assign off     = 32'({PADDR[APB_ADDR_WIDTH-1:2], 2'b00});
  assign in_cnt  = (off >= CNT_BASE);
  assign rel     = off - CNT_BASE;
  assign idx     = rel / CNT_STRIDE;
  assign hi_sel  = rel[2];
  assign idx_ok  = (idx < 32'(NUM_CNT));
  assign wdata_m = PWDATA[NUM_CNT-1:0];
  assign unused_bits = ^{PWDATA, PADDR[1:0]};

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (idx == 32'(i)) sel_cnt = cnt_t'(cnt_arr[i]);
    end
  end

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    if (in_cnt) begin
      // Counter window is read-only; out-of-range channels are errors too.
      if (!idx_ok || PWRITE) err   = 1'b1;
      else if (hi_sel)       rdata = hold_q;
      else                   rdata = sel_cnt[31:0];
    end else begin
      case (off)
        OFF_CLEAR:           rdata = '0;
        OFF_START, OFF_STOP: rdata = 32'(act_vec);
        OFF_OVF:             rdata = 32'(ovf_vec);
`ifdef PERF_CNT_OVF_IRQ_EN
        OFF_IRQ_MASK:        rdata = 32'(irq_mask_q);
`endif
        default:             err   = 1'b1;
      endcase
    end
  end

  assign wr_ok = access & PWRITE & ~err;
  assign lo_rd = access & ~PWRITE & ~err & in_cnt & ~hi_sel;

  assign clr_vec   = (wr_ok && off == OFF_CLEAR) ? wdata_m : '0;
  assign start_vec = (wr_ok && off == OFF_START) ? wdata_m : '0;
  assign stop_vec  = (wr_ok && off == OFF_STOP)  ? wdata_m : '0;
  assign ovf_w1c   = (wr_ok && off == OFF_OVF)   ? wdata_m : '0;

  assign PRDATA    = (access && !PWRITE && !err) ? rdata : '0;
  assign PSLVERR   = access & err;
  assign PREADY    = 1'b1;
  assign cnt_act_o = act_vec;

  // Any CNT_LO read captures the upper half of that same sample.
  always_ff @(posedge HCLK) begin
    if (HRESET)     hold_q <= '0;
    else if (lo_rd) hold_q <= sel_cnt[63:32];
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_slice
    perf_cnt_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_WIDTH)
    ) u_slice (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .clr     (clr_vec[g]),
      .start   (start_vec[g]),
      .stop    (stop_vec[g]),
      .ovf_clr (ovf_w1c[g]),
      .inc     (evt_inc_i[g*INC_WIDTH +: INC_WIDTH]),
      .cnt     (cnt_arr[g]),
      .act     (act_vec[g]),
      .ovf     (ovf_vec[g])
    );
  end

`ifdef PERF_CNT_OVF_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_ok && off == OFF_IRQ_MASK) irq_mask_q <= wdata_m;
      irq_q <= |(ovf_vec & irq_mask_q);
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_perf_cnt_bank.sv
module tb_apb_perf_cnt_bank;

  localparam int NUM = 6;
  localparam int CW  = 36;
  localparam int IW  = 32;
  localparam int AW  = 12;
  localparam logic [63:0] MOD = 64'd1 << CW;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [AW-1:0]   PADDR;
  logic [31:0]     PWDATA;
  logic            PWRITE, PSEL, PENABLE;
  logic [31:0]     PRDATA;
  logic            PREADY, PSLVERR;
  logic [NUM*IW-1:0] evt_inc_i;
  logic [NUM-1:0]  cnt_act_o;
  logic            irq_o;

  logic [31:0]     evt [NUM];
  int              evt_mode;
  logic [NUM-1:0]  evt_en;
  logic [31:0]     custom_val;

  logic [63:0]     m_cnt [NUM];
  logic [NUM-1:0]  m_act, m_ovf, m_mask;
  logic [31:0]     m_hold;
  logic            m_irq;

  logic [31:0]     last_rd, lo_s, hi_s;
  logic            last_err;
  int              checks = 0;
  int              failures = 0;

  apb_perf_cnt_bank #(
    .NUM_CNT(NUM), .CNT_WIDTH(CW), .INC_WIDTH(IW), .APB_ADDR_WIDTH(AW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .evt_inc_i(evt_inc_i),
    .cnt_act_o(cnt_act_o), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  always_comb begin
    evt_inc_i = '0;
    for (int i = 0; i < NUM; i++) evt_inc_i[i*IW +: IW] = evt[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected combinational response of the register map for the current request.
  function automatic void model_read(output logic err, output logic [31:0] data);
    logic [31:0] off, rel;
    int idx;
    off  = {20'd0, PADDR[AW-1:2], 2'b00};
    err  = 1'b0;
    data = '0;
    if (off >= 32'h100) begin
      rel = off - 32'h100;
      idx = int'(rel / 8);
      if (idx >= NUM || PWRITE) err = 1'b1;
      else if (rel % 8 == 4)    data = m_hold;
      else                      data = m_cnt[idx][31:0];
    end else if (off == 32'h0) data = '0;
    else if (off == 32'h4 || off == 32'h8) data = 32'(m_act);
    else if (off == 32'hC) data = 32'(m_ovf);
`ifdef PERF_CNT_OVF_IRQ_EN
    else if (off == 32'h10) data = 32'(m_mask);
`endif
    else err = 1'b1;
  endfunction

  task automatic model_update();
    logic err, acc, wr, set, irq_n;
    logic [31:0] d, off, rel;
    logic [63:0] s;
    logic [NUM-1:0] w;
    if (HRESET) begin
      for (int i = 0; i < NUM; i++) m_cnt[i] = '0;
      m_act = '0; m_ovf = '0; m_mask = '0; m_hold = '0; m_irq = 1'b0;
      return;
    end
    acc = PSEL & PENABLE;
    model_read(err, d);
    off = {20'd0, PADDR[AW-1:2], 2'b00};
    rel = off - 32'h100;
    wr  = acc & PWRITE & ~err;
    w   = PWDATA[NUM-1:0];
`ifdef PERF_CNT_OVF_IRQ_EN
    irq_n = |(m_ovf & m_mask);
`else
    irq_n = 1'b0;
`endif
    if (acc && !PWRITE && !err && off >= 32'h100 && rel % 8 == 0)
      m_hold = 32'(m_cnt[rel / 8] >> 32);
    for (int i = 0; i < NUM; i++) begin
      if (wr && off == 32'h0 && w[i]) begin
        m_cnt[i] = '0;
        m_ovf[i] = 1'b0;
      end else begin
        set = 1'b0;
        if (m_act[i]) begin
          s = m_cnt[i] + 64'(evt[i]);
          if (s >= MOD) begin set = 1'b1; s = s - MOD; end
          m_cnt[i] = s;
        end
        if (set) m_ovf[i] = 1'b1;
        else if (wr && off == 32'hC && w[i]) m_ovf[i] = 1'b0;
      end
    end
    if (wr && off == 32'h4) m_act = m_act | w;
    if (wr && off == 32'h8) m_act = m_act & ~w;
`ifdef PERF_CNT_OVF_IRQ_EN
    if (wr && off == 32'h10) m_mask = w;
`endif
    m_irq = irq_n;
  endtask

  task automatic gen_events();
    for (int i = 0; i < NUM; i++) begin
      if (!evt_en[i]) evt[i] = '0;
      else case (evt_mode)
        1: evt[i] = 32'd1;
        2: evt[i] = $urandom_range(0, 3);
        3: evt[i] = $urandom;
        4: evt[i] = 32'hFFFF_FFFF;
        5: evt[i] = custom_val;
        default: evt[i] = '0;
      endcase
    end
  endtask

  // One clock: inputs set just after an edge, response checked mid-cycle.
  task automatic tick();
    logic err;
    logic [31:0] d;
    gen_events();
    #4;
    if (PSEL && PENABLE) begin
      model_read(err, d);
      chk($sformatf("pslverr@%0h", PADDR), 64'(PSLVERR), 64'(err));
      if (!PWRITE) chk($sformatf("prdata@%0h", PADDR), 64'(PRDATA), 64'(d));
      last_rd  = PRDATA;
      last_err = PSLVERR;
    end else begin
      chk("idle_prdata", 64'(PRDATA), 64'd0);
      chk("idle_pslverr", 64'(PSLVERR), 64'd0);
    end
    @(posedge HCLK);
    model_update();
    #1;
    chk("cnt_act_o", 64'(cnt_act_o), 64'(m_act));
    chk("irq_o", 64'(irq_o), 64'(m_irq));
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] dat);
    PADDR = a; PWDATA = dat; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a <= 'h14; a += 4) apb_read(AW'(a));
    for (int i = 0; i <= NUM; i++) begin
      apb_read(AW'(32'h100 + 8*i));
      apb_read(AW'(32'h104 + 8*i));
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = 4 * $urandom_range(0, 6);
      default: a = 32'h100 + 8 * $urandom_range(0, 7) + 4 * $urandom_range(0, 1);
    endcase
    return AW'(a | $urandom_range(0, 3));
  endfunction

  initial begin
    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0;
    PENABLE = 1'b0; evt_mode = 0; evt_en = '1; custom_val = '0;
    last_rd = '0; last_err = 1'b0;
    for (int i = 0; i < NUM; i++) evt[i] = '0;
    @(posedge HCLK); #1;
    tick(); tick();
    HRESET = 1'b0;
    tick();

    // Reset state and error decode
    read_all();
    apb_read(AW'(32'h100 + 8*NUM));
    chk("lo_oob_slverr", 64'(last_err), 64'd1);
    chk("lo_oob_prdata", 64'(last_rd), 64'd0);
    apb_write(12'h100, 32'hFFFF_FFFF);
    apb_write(12'h014, 32'hFFFF_FFFF);

    // START/STOP edge rules with one event per cycle on every channel
    evt_mode = 1;
    apb_write(12'h004, 32'hFFFF_FFC5);
    for (int n = 0; n < 10; n++) tick();
    apb_write(12'h008, 32'hFFFF_FFC5);
    evt_mode = 0;
    apb_read(12'h100); chk("start_stop_cnt0", 64'(last_rd), 64'd12);
    apb_read(12'h110); chk("start_stop_cnt2", 64'(last_rd), 64'd12);
    apb_read(12'h108); chk("inactive_cnt1", 64'(last_rd), 64'd0);
    apb_read(12'h004); chk("start_reg", 64'(last_rd), 64'd0);

    // CLEAR racing an event on an active counter
    apb_write(12'h004, 32'h1);
    evt_mode = 1;
    apb_write(12'h000, 32'h1);
    evt_mode = 0;
    apb_read(12'h100); chk("clear_wins", 64'(last_rd), 64'd0);

    // Preload counter 0 to all-ones, then wrap
    evt_en = 6'b000001;
    evt_mode = 4;
    for (int n = 0; n < 16; n++) tick();
    evt_mode = 5; custom_val = 32'd15; tick();
    evt_mode = 0;
    apb_read(12'h100); chk("preload_lo", 64'(last_rd), 64'hFFFF_FFFF);
    apb_read(12'h104); chk("preload_hi", 64'(last_rd), 64'hF);
    evt_mode = 5; custom_val = 32'd1; tick();
    evt_mode = 0;
    apb_read(12'h100); chk("wrap_lo", 64'(last_rd), 64'd0);
    apb_read(12'h00C); chk("wrap_ovf", 64'(last_rd), 64'h1);
    apb_write(12'h00C, 32'h1);
    apb_read(12'h00C); chk("ovf_w1c", 64'(last_rd), 64'h0);

    // Hold coherence across a carry out of bit 31
    evt_en = 6'b000010;
    apb_write(12'h004, 32'h2);
    evt_mode = 5; custom_val = 32'hFFFF_FFFE; tick();
    evt_mode = 1;
    apb_read(12'h108); lo_s = last_rd;
    apb_read(12'h10C); hi_s = last_rd;
    chk("coherent_pair", {hi_s, lo_s}, 64'h0000_0000_FFFF_FFFF);
    apb_read(12'h108);
    apb_read(12'h100);
    apb_read(12'h10C); chk("hold_overwritten", 64'(last_rd), 64'd0);
    apb_read(12'h108);
    apb_read(12'h10C); chk("hold_after_carry", 64'(last_rd), 64'd1);

`ifdef PERF_CNT_OVF_IRQ_EN
    // Masked overflow interrupt: only counter 1 may raise it
    evt_mode = 0;
    apb_write(12'h010, 32'h2);
    apb_write(12'h004, 32'h3);
    evt_en = 6'b000001; evt_mode = 4;
    for (int n = 0; n < 20; n++) tick();
    chk("irq_unmasked_ovf0", 64'(irq_o), 64'd0);
    evt_en = 6'b000010;
    for (int n = 0; n < 20; n++) tick();
    evt_mode = 0;
    tick();
    chk("irq_masked_ovf1", 64'(irq_o), 64'd1);
    apb_write(12'h00C, 32'h2);
    tick();
    chk("irq_after_w1c", 64'(irq_o), 64'd0);
`endif

    // Randomized traffic against the model
    evt_en = '1;
    evt_mode = 3;
    apb_write(12'h004, 32'h3F);
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 11))
        0:       apb_write(12'h00C, $urandom);
        1:       apb_write(12'h000, $urandom & $urandom & $urandom);
        2:       apb_write(12'h004, $urandom);
        3:       apb_write(12'h008, $urandom & $urandom);
        4:       apb_write(12'h010, $urandom);
        5:       apb_write(rand_addr(), $urandom);
        6:       begin evt_mode = $urandom_range(0, 4); tick(); end
        default: apb_read(rand_addr());
      endcase
    end
    read_all();

    // Reset while counters run and a write is in flight
    evt_mode = 1;
    apb_write(12'h008, 32'h3F);
    apb_write(12'h004, 32'h2A);
    for (int n = 0; n < 5; n++) tick();
    PADDR = 12'h004; PWDATA = 32'h3F; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1; HRESET = 1'b1;
    tick();
    chk("reset_act", 64'(cnt_act_o), 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; HRESET = 1'b0;
    tick();
    evt_mode = 0;
    read_all();
    apb_read(12'h102); chk("post_reset_cnt0", 64'(last_rd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_perf_cnt_bank.md
# apb_perf_cnt_bank

Parametrised APB performance-counter bank: NUM_CNT counters of CNT_WIDTH bits, each incremented by a per-channel event input. It provides APB-programmable start/stop/clear, sticky overflow status and tear-free reads of counters wider than 32 bits. It replaces the fixed-count AMO perf-counter controller by owning the counters itself rather than only gating external ones. It sits on the peripheral APB bus next to the AXI atomics adapter, which drives its event inputs.

## Interface
- NUM_CNT, 8: number of counters, 1..32
- CNT_WIDTH, 48: counter width, 1..64
- INC_WIDTH, 1: width of each per-cycle increment
- APB_ADDR_WIDTH, 12: APB address width, ≥ 9
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- PADDR  in  APB_ADDR_WIDTH  APB address (byte; bits [1:0] ignored)
- PWDATA  in  32  APB write data
- PWRITE / PSEL / PENABLE  in  1 each  APB control
- PRDATA  out  32  APB read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  error response
- evt_inc_i  in  NUM_CNT × INC_WIDTH  per-channel increment this cycle
- cnt_act_o  out  NUM_CNT  active mask
- irq_o  out  1  overflow interrupt (macro only)

## Operation
- Access phase is PSEL & PENABLE. Writes take effect at the next HCLK edge. Reads are combinational in the access phase.
- Register map (byte offsets):
  - 0x000 CLEAR, W: bit i = 1 zeroes counter i and its overflow bit. Reads 0.
  - 0x004 START, W1S on the active mask. R: active mask.
  - 0x008 STOP, W1C on the active mask. R: active mask.
  - 0x00C OVF, W1C. R: sticky overflow mask.
  - 0x010 OVF_IRQ_MASK, RW. Present only with the macro.
  - 0x100+8·i CNT_LO[i], RO. Returns counter bits [31:0]. The read latches bits [CNT_WIDTH-1:32] (zero-extended) into a shared hold register.
  - 0x104+8·i CNT_HI[i], RO. Returns the hold register, not the live counter.
- Write-data bits ≥ NUM_CNT in mask registers are ignored. Those bits read as 0.
- Counter update each cycle:
  - If a CLEAR bit is written: counter ← 0.
  - Else if the counter is active: counter ← (counter + evt_inc_i[i]) mod 2^CNT_WIDTH.
  - Else: hold.
- Overflow: if the carry out of bit CNT_WIDTH-1 occurs, OVF[i] is set (sticky). The counter wraps modulo 2^CNT_WIDTH.
- PSLVERR = 1 in the access phase for any of:
  - an unmapped offset;
  - counter index ≥ NUM_CNT;
  - a write to CNT_LO/CNT_HI.
  - In each of these cases PRDATA = 0 and there is no state change.
- CNT_WIDTH ≤ 32: CNT_HI returns 0. Bits above CNT_WIDTH in CNT_LO read 0.

## Timing
- Reset values: all counters 0, active mask 0, OVF 0, hold register 0, OVF_IRQ_MASK 0, cnt_act_o 0, irq_o 0, PRDATA 0 when idle, PSLVERR 0.
- Increment latency: an event in cycle t is visible in a CNT_LO read at cycle t+1.
- START written in cycle t: the counter is active from t+1. The event in cycle t is not counted. STOP is symmetric: the event in cycle t is still counted.
- CLEAR and an event in the same cycle: CLEAR wins, and the counter reads 0 at t+1.
- OVF W1C and a new overflow in the same cycle: set wins.
- HRESET asserted mid-operation: all state returns to reset values at the next edge, regardless of APB activity.
- Hold-register coherence: a CNT_LO read then a CNT_HI read of the same i returns one consistent 64-bit sample, even if the counter carries across bit 32 in between. An intervening CNT_LO read of any counter overwrites the hold register.

## Configuration
- PERF_CNT_OVF_IRQ_EN defined:
  - OVF_IRQ_MASK is implemented.
  - irq_o is registered and equals |(OVF & OVF_IRQ_MASK), one cycle after the OVF/mask update.
- PERF_CNT_OVF_IRQ_EN undefined:
  - offset 0x010 is unmapped (PSLVERR);
  - irq_o is tied 0;
  - OVF status is still implemented.

## Structure
- Package perf_cnt_pkg holds:
  - register offset localparams;
  - the CNT_BASE and CNT_STRIDE constants;
  - typedef cnt_t (64-bit) used for the hold register and read muxing.
- Sub-module perf_cnt_slice: one counter, its active bit, its overflow bit, and its clear/increment priority logic. It is instantiated NUM_CNT times with a generate loop. The top module owns APB decode, the hold register and the IRQ.

## Test plan
- Reset, then read all registers. Expected: everything 0 and PSLVERR 0; a CNT_LO read at index NUM_CNT gives PSLVERR 1 and PRDATA 0.
- START 0x5, drive evt_inc_i[*]=1 for 10 cycles, STOP 0x5. Expected: counters 0 and 2 read 10, 11 or 12 per the start/stop edge rules; all others 0.
- Clear/event race, CNT_WIDTH=8, preload counter 0 to 0xFF by 255 events. Expected: CLEAR bit 0 with a same-cycle event gives 0; otherwise one more event wraps to 0x00 with OVF=0x1, and W1C OVF returns 0.
- CNT_WIDTH=48, counter at 0x0000_FFFF_FFFF with continuous events. Expected: read LO, then HI two cycles later; the pair is consistent (HI 0x0000, LO ≥ 0xFFFFFFFF sample), never HI 0x0001 with a stale LO.
- With PERF_CNT_OVF_IRQ_EN, mask 0x2, overflow counter 1. Expected: irq_o rises one cycle after OVF[1] sets and clears one cycle after W1C; an overflow of counter 0 leaves irq_o at 0.
- Assert HRESET while counters are active and an APB write is in progress. Expected: all state 0 next cycle and the write is discarded.
